// File: rtl/sdram_rv_bridge.sv
// sdram_rv_bridge: requester side of the SDRAM controller's toggle req/ack port.
// Splits each 32-bit RV native-bus access into one or two 16-bit toggle
// transactions on the controller's 2MB bank-1 port (low halfword first).
// Optional feature macro: SDRAM_RV_RDCACHE_EN adds a one-entry 32-bit read
// buffer. Without it, every read goes to the SDRAM.
module sdram_rv_bridge #(
  parameter int RD_LAT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [20:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic [19:0] rv_addr,
  output logic [15:0] rv_din,
  output logic [1:0]  rv_ds,
  output logic        rv_we,
  output logic        rv_req,
  input  logic        rv_req_ack,
  input  logic [15:0] rv_dout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO      = 3'd1,
    WAIT_LO = 3'd2,
    HI      = 3'd3,
    WAIT_HI = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(RD_LAT);

  state_t        state;
  logic [CW-1:0] lat_cnt;
  logic [18:0]   word_addr;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          is_wr;
  logic          ack_match;
  logic          unused_addr_bits;

  // The byte offset within the word has no meaning on this bus.
  assign unused_addr_bits = ^mem_addr[1:0];

  // The controller has finished the last request once its ack equals our toggle.
  assign ack_match = (rv_req == rv_req_ack);

`ifdef SDRAM_RV_RDCACHE_EN
  logic        cache_valid;
  logic [18:0] cache_tag;
  logic [31:0] cache_data;
  logic        cache_hit;

  // Read hit on the buffered word; only meaningful while a request is offered.
  assign cache_hit = (mem_wstrb == 4'b0000) && cache_valid && (cache_tag == mem_addr[20:2]);
`endif

  // Transaction sequencer: all bus-side and controller-side outputs are registered here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      word_addr <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      is_wr     <= 1'b0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      rv_addr   <= '0;
      rv_din    <= '0;
      rv_ds     <= '0;
      rv_we     <= 1'b0;
      rv_req    <= 1'b0;
`ifdef SDRAM_RV_RDCACHE_EN
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            // Capture the request so later phases do not depend on the bus holding it.
            word_addr <= mem_addr[20:2];
            wdata_q   <= mem_wdata;
            wstrb_q   <= mem_wstrb;
            is_wr     <= (mem_wstrb != 4'b0000);
`ifdef SDRAM_RV_RDCACHE_EN
            if (cache_hit) begin
              mem_rdata <= cache_data;
              mem_ready <= 1'b1;
              state     <= DONE;
            end else
`endif
            // A mismatched ack (e.g. skew left over from a reset) blocks new requests.
            if (ack_match) begin
              if (mem_wstrb != 4'b0000 && mem_wstrb[1:0] == 2'b00) begin
                state <= HI;
              end else begin
                state <= LO;
              end
            end
          end
        end

        LO: begin
          rv_addr <= {word_addr, 1'b0};
          rv_din  <= wdata_q[15:0];
          rv_ds   <= is_wr ? wstrb_q[1:0] : 2'b11;
          rv_we   <= is_wr;
          rv_req  <= ~rv_req;
          state   <= WAIT_LO;
        end

        WAIT_LO: begin
          if (lat_cnt != '0) begin
            // Read pipe: sample the controller data RD_LAT edges after the ack matched.
            if (lat_cnt == LAT_LAST) begin
              mem_rdata[15:0] <= rv_dout;
              lat_cnt         <= '0;
              state           <= HI;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end else if (ack_match) begin
            if (!is_wr) begin
              lat_cnt <= CW'(1);
            end else if (wstrb_q[3:2] != 2'b00) begin
              state <= HI;
            end else begin
              mem_ready <= 1'b1;
              state     <= DONE;
            end
          end
        end

        HI: begin
          rv_addr <= {word_addr, 1'b1};
          rv_din  <= wdata_q[31:16];
          rv_ds   <= is_wr ? wstrb_q[3:2] : 2'b11;
          rv_we   <= is_wr;
          rv_req  <= ~rv_req;
          state   <= WAIT_HI;
        end

        WAIT_HI: begin
          if (lat_cnt != '0) begin
            if (lat_cnt == LAT_LAST) begin
              mem_rdata[31:16] <= rv_dout;
              lat_cnt          <= '0;
              mem_ready        <= 1'b1;
              state            <= DONE;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end else if (ack_match) begin
            if (!is_wr) begin
              lat_cnt <= CW'(1);
            end else begin
              mem_ready <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
`ifdef SDRAM_RV_RDCACHE_EN
          if (!is_wr) begin
            // Reads (miss or hit) leave the completed word in the buffer.
            cache_valid <= 1'b1;
            cache_tag   <= word_addr;
            cache_data  <= mem_rdata;
          end else if (cache_valid && cache_tag == word_addr) begin
            // Keep the buffered copy coherent with the bytes just written.
            for (int b = 0; b < 4; b++) begin
              if (wstrb_q[b]) begin
                cache_data[8*b +: 8] <= wdata_q[8*b +: 8];
              end
            end
          end
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_rv_bridge.sv
// tb_sdram_rv_bridge: scoreboard bench for sdram_rv_bridge.
// A behavioural SDRAM controller answers toggle requests and checks each one
// against an expected-request queue; a monitor checks every mem_ready against a
// word-level reference memory. SDRAM_RV_RDCACHE_EN selects the buffered build.
module tb_sdram_rv_bridge;
  localparam int RD_LAT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [20:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [19:0] rv_addr;
  logic [15:0] rv_din;
  logic [1:0]  rv_ds;
  logic        rv_we;
  logic        rv_req;
  logic        rv_req_ack;
  logic [15:0] rv_dout;

  // Controller side: automatic model, or manual drive for the reset scenario.
  logic        ctrl_en = 1'b1;
  logic        auto_ack = 1'b0;
  logic        man_ack = 1'b0;
  logic [15:0] auto_dout = '0;
  logic [15:0] man_dout = '0;
  int          ack_delay_fixed = -1;

  assign rv_req_ack = ctrl_en ? auto_ack : man_ack;
  assign rv_dout    = ctrl_en ? auto_dout : man_dout;

  always #5 clk = ~clk;

  sdram_rv_bridge #(.RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .rv_addr    (rv_addr),
    .rv_din     (rv_din),
    .rv_ds      (rv_ds),
    .rv_we      (rv_we),
    .rv_req     (rv_req),
    .rv_req_ack (rv_req_ack),
    .rv_dout    (rv_dout)
  );

  typedef struct packed {
    logic [19:0] addr;
    logic        we;
    logic [1:0]  ds;
    logic [15:0] din;
  } req_t;

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } rsp_t;

  req_t        exp_req[$];
  rsp_t        sb[$];
  logic [15:0] sdram[int];
  logic [31:0] ref_mem[int];
  int          checks = 0;
  int          errors = 0;
  int          txn_no = 0;
`ifdef SDRAM_RV_RDCACHE_EN
  logic        tb_cv = 1'b0;
  logic [18:0] tb_ct = '0;
`endif

  // Contents of never-written SDRAM halfwords.
  function automatic logic [15:0] dflt(input logic [19:0] h);
    return h[15:0] ^ {h[19:16], 12'h3C5};
  endfunction

  function automatic logic [15:0] sd_rd(input logic [19:0] h);
    if (sdram.exists(int'(h))) return sdram[int'(h)];
    return dflt(h);
  endfunction

  // Reference memory at 32-bit word granularity.
  function automatic logic [31:0] ref_rd(input logic [18:0] w);
    if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
    return {dflt({w, 1'b1}), dflt({w, 1'b0})};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic stop_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Issue one RV access, queue its expectations, wait for completion.
  task automatic do_txn(input logic [20:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [18:0] w;
    logic [31:0] cur;
    req_t        r;
    rsp_t        s;
    bit          hit;
    bit          done;
    w = a[20:2];
    if (ws == 4'b0000) begin
      hit = 1'b0;
`ifdef SDRAM_RV_RDCACHE_EN
      hit   = tb_cv && (tb_ct == w);
      tb_cv = 1'b1;
      tb_ct = w;
`endif
      if (!hit) begin
        r.addr = {w, 1'b0}; r.we = 1'b0; r.ds = 2'b11; r.din = '0;
        exp_req.push_back(r);
        r.addr = {w, 1'b1};
        exp_req.push_back(r);
      end
      s.rd = 1'b1;
      s.data = ref_rd(w);
      sb.push_back(s);
    end else begin
      cur = ref_rd(w);
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
      end
      ref_mem[int'(w)] = cur;
      if (ws[1:0] != 2'b00) begin
        r.addr = {w, 1'b0}; r.we = 1'b1; r.ds = ws[1:0]; r.din = wd[15:0];
        exp_req.push_back(r);
      end
      if (ws[3:2] != 2'b00) begin
        r.addr = {w, 1'b1}; r.we = 1'b1; r.ds = ws[3:2]; r.din = wd[31:16];
        exp_req.push_back(r);
      end
      s.rd = 1'b0;
      s.data = cur;
      sb.push_back(s);
    end
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (mem_ready) done = 1'b1;
    end
    if (!done) stop_now("txn_ready");
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  // Reset during WAIT_HI, release with the ack skewed, then recover.
  task automatic reset_test();
    bit seen;
    bit quiet;
    man_ack = auto_ack;
    ctrl_en = 1'b0;
    mem_valid = 1'b1;
    mem_addr  = 21'h000500;
    mem_wstrb = 4'b0000;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (rv_req !== man_ack) seen = 1'b1;
    end
    if (!seen) stop_now("rst_lo_toggle");
    @(posedge clk); #1 man_ack = rv_req;
    repeat (RD_LAT) @(posedge clk);
    #1 man_dout = 16'h1111;
    @(posedge clk); #1 man_dout = 16'h0000;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (rv_req !== man_ack) seen = 1'b1;
    end
    if (!seen) stop_now("rst_hi_toggle");
    // Bridge now waits for the high-half ack.
    @(posedge clk); #1;
    resetn = 1'b0;
    mem_valid = 1'b0;
`ifdef SDRAM_RV_RDCACHE_EN
    tb_cv = 1'b0;
`endif
    @(negedge clk);
    chk("rst_mid_req", rv_req, 0);
    chk("rst_mid_rdata", mem_rdata, 0);
    chk("rst_mid_ready", mem_ready, 0);
    @(posedge clk); #1;
    man_ack = 1'b1;
    resetn  = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = 21'h000504;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (rv_req !== 1'b0 || mem_ready !== 1'b0) quiet = 1'b0;
    end
    chk("skew_idle", quiet, 1);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    man_ack = 1'b0;
    @(negedge clk); #1;
    ctrl_en = 1'b1;
    @(posedge clk); #1;
  endtask

  // Behavioural SDRAM controller: answers toggles, checks request contents/stability.
  initial begin : ctrl
    req_t r;
    req_t e;
    int   d;
    logic stable;
    logic tg;
    forever begin
      @(negedge clk);
      if (!ctrl_en) begin
        auto_ack = man_ack;
      end else if (rv_req !== auto_ack) begin
        r.addr = rv_addr; r.we = rv_we; r.ds = rv_ds; r.din = rv_din;
        tg = rv_req;
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual=%h required=none", r.addr);
        end else begin
          e = exp_req.pop_front();
          chk("req_addr", r.addr, e.addr);
          chk("req_we", r.we, e.we);
          chk("req_ds", r.ds, e.ds);
          if (e.we) chk("req_din", r.din, e.din);
        end
        if (r.we) begin
          e.din = sd_rd(r.addr);
          if (r.ds[0]) e.din[7:0]  = r.din[7:0];
          if (r.ds[1]) e.din[15:8] = r.din[15:8];
          sdram[int'(r.addr)] = e.din;
        end
        d = (ack_delay_fixed >= 0) ? ack_delay_fixed : int'($urandom_range(0, 4));
        stable = 1'b1;
        repeat (d) begin
          @(negedge clk);
          if (rv_req !== tg || rv_addr !== r.addr || rv_we !== r.we ||
              rv_ds !== r.ds || rv_din !== r.din || mem_ready !== 1'b0) stable = 1'b0;
        end
        if (d > 0) chk("req_stable", stable, 1);
        @(posedge clk); #1 auto_ack = tg;
        if (!r.we) begin
          repeat (RD_LAT) @(posedge clk);
          #1 auto_dout = sd_rd(r.addr);
          @(posedge clk);
          #1 auto_dout = 16'($urandom);
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on every mem_ready.
  initial begin : mon
    logic prev;
    rsp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        if (prev) begin
          checks++;
          errors++;
          $display("FAIL ready_width actual=2+ cycles required=1 cycle");
        end else if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready actual=1 required=0");
        end else begin
          e = sb.pop_front();
          txn_no++;
          $display("txn %0d %s data=%h", txn_no, e.rd ? "rd" : "wr", e.rd ? mem_rdata : e.data);
          if (e.rd) chk("rdata", mem_rdata, e.data);
        end
      end
      prev = mem_ready;
    end
  end

  initial begin : watchdog
    #500000;
    stop_now("global");
  end

  initial begin : stim
    logic [20:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", mem_ready, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_req", rv_req, 0);
    chk("rst_addr", rv_addr, 0);
    chk("rst_din", rv_din, 0);
    chk("rst_ds", rv_ds, 0);
    chk("rst_we", rv_we, 0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    sdram[32'h82] = 16'hBEEF;
    sdram[32'h83] = 16'hDEAD;
    ref_mem[32'h41] = 32'hDEADBEEF;
    do_txn(21'h000104, 32'h0, 4'b0000);
    do_txn(21'h000200, 32'h12345678, 4'b1111);
    do_txn(21'h000200, 32'h0, 4'b0000);
    do_txn(21'h000300, 32'h00AA0000, 4'b0100);
    do_txn(21'h000300, 32'h0, 4'b0000);
    do_txn(21'h000104, 32'h0, 4'b0000);
    do_txn(21'h000104, 32'h00000077, 4'b0001);
    do_txn(21'h000104, 32'h0, 4'b0000);
    do_txn(21'h1FFFFC, 32'hCAFEF00D, 4'b1001);
    do_txn(21'h1FFFFC, 32'h0, 4'b0000);
    ack_delay_fixed = 20;
    do_txn(21'h000404, 32'h11223344, 4'b1111);
    do_txn(21'h000404, 32'h0, 4'b0000);
    ack_delay_fixed = -1;

    reset_test();
    do_txn(21'h000504, 32'h0, 4'b0000);

    repeat (60) begin
      a  = {11'h010, 8'($urandom_range(0, 15)), 2'($urandom)};
      wd = $urandom;
      ws = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      do_txn(a, wd, ws);
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("req_drained", exp_req.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
